// File: rtl/relin_accumulate_pkg.sv
// Shared constants, tile type and FSM state encoding for the relin accumulate stage.
package relin_accumulate_pkg;
  localparam int DEGREE_N  = 16;
  localparam int TILE_N    = 4;
  localparam int BIT_WIDTH = 32;
  localparam logic [BIT_WIDTH-1:0] Q = 32'd12289;

  localparam int NT    = DEGREE_N / TILE_N;
  localparam int CNT_W = $clog2(NT + 1);
  localparam int IDX_W = $clog2(2 * NT);

  localparam logic [CNT_W-1:0] NT_CNT    = CNT_W'(NT);
  localparam logic [CNT_W-1:0] NT_M1_CNT = CNT_W'(NT - 1);
  localparam logic [IDX_W-1:0] NT_IDX    = IDX_W'(NT);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(2 * NT - 1);

  typedef logic [TILE_N-1:0][BIT_WIDTH-1:0] tile_t;

  typedef enum logic [1:0] {
    LOAD_D,
    WAIT_R,
    ACCUM,
    DRAIN
  } state_t;
endpackage

// File: rtl/mod_add_tile.sv
// Combinational per-lane (a + (b mod Q)) mod Q; a is assumed already reduced.
module mod_add_tile
  import relin_accumulate_pkg::*;
(
  input  tile_t a,
  input  tile_t b,
  output tile_t y
);
  generate
    for (genvar gi = 0; gi < TILE_N; gi++) begin : g_lane
      logic [BIT_WIDTH-1:0] b_red;
      logic [BIT_WIDTH:0]   sum;
      assign b_red = b[gi] % Q;
      assign sum   = {1'b0, a[gi]} + {1'b0, b_red};
      assign y[gi] = (sum >= {1'b0, Q}) ? BIT_WIDTH'(sum - {1'b0, Q}) : sum[BIT_WIDTH-1:0];
    end
  endgenerate
endmodule

// File: rtl/relin_accumulate.sv
// Holds d0/d1, adds the non-stallable relin c0/c1 burst mod Q, then drains ct0/ct1 tiles.
module relin_accumulate
  import relin_accumulate_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        d_valid_i,
  output logic                        d_ready_o,
  input  logic [TILE_N*BIT_WIDTH-1:0] d_coeff_i,
  input  logic                        r_valid_i,
  input  logic                        r_key_select_i,
  input  logic [TILE_N*BIT_WIDTH-1:0] r_coeff_i,
  output logic                        r_ready_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        poly_sel_o,
  output logic [TILE_N*BIT_WIDTH-1:0] coeff_o,
  output logic                        error_o
);
  tile_t d_buf   [2*NT];
  tile_t res_buf [2*NT];

  state_t           state_reg;
  logic [IDX_W-1:0] d_cnt_reg;
  logic [IDX_W-1:0] o_cnt_reg;
  logic [CNT_W-1:0] c0_cnt_reg;
  logic [CNT_W-1:0] c1_cnt_reg;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_other_cnt;
  logic [IDX_W-1:0] r_addr;
  logic [IDX_W-1:0] o_cnt_next;
  logic             r_open;
  logic             r_take;
  logic             d_take;
  logic             accum_last;
  logic             drain_take;
  tile_t            sum_tile;

  assign r_cnt       = r_key_select_i ? c1_cnt_reg : c0_cnt_reg;
  assign r_other_cnt = r_key_select_i ? c0_cnt_reg : c1_cnt_reg;
  assign r_open      = (state_reg == WAIT_R) || (state_reg == ACCUM);
  assign r_take      = r_open && r_valid_i && (r_cnt != NT_CNT);
  assign r_addr      = (r_key_select_i ? NT_IDX : '0) + IDX_W'(r_cnt);
  // The beat that fills the last open slot of both polys hands straight over to DRAIN.
  assign accum_last  = r_take && (r_other_cnt == NT_CNT) && (r_cnt == NT_M1_CNT);
  assign d_take      = (state_reg == LOAD_D) && d_valid_i && d_ready_o;
  assign drain_take  = valid_o && ready_i;
  assign o_cnt_next  = o_cnt_reg + IDX_W'(1);

  mod_add_tile u_add (
    .a (d_buf[r_addr]),
    .b (tile_t'(r_coeff_i)),
    .y (sum_tile)
  );

  always_ff @(posedge clk) begin
    if (d_take) d_buf[d_cnt_reg] <= tile_t'(d_coeff_i);
    if (r_take) res_buf[r_addr] <= sum_tile;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= LOAD_D;
      d_cnt_reg  <= '0;
      o_cnt_reg  <= '0;
      c0_cnt_reg <= '0;
      c1_cnt_reg <= '0;
      d_ready_o  <= 1'b0;
      r_ready_o  <= 1'b0;
      valid_o    <= 1'b0;
      poly_sel_o <= 1'b0;
      coeff_o    <= '0;
      error_o    <= 1'b0;
    end else begin
      // Relin beats cannot be stalled, so anything not absorbed is a protocol violation.
      if (r_valid_i && !r_take) error_o <= 1'b1;
      if (r_take) begin
        if (r_key_select_i) c1_cnt_reg <= c1_cnt_reg + CNT_W'(1);
        else                c0_cnt_reg <= c0_cnt_reg + CNT_W'(1);
      end
      case (state_reg)
        LOAD_D: begin
          d_ready_o <= 1'b1;
          if (d_take) begin
            if (d_cnt_reg == LAST_IDX) begin
              d_cnt_reg <= '0;
              d_ready_o <= 1'b0;
              r_ready_o <= 1'b1;
              state_reg <= WAIT_R;
            end else begin
              d_cnt_reg <= d_cnt_reg + IDX_W'(1);
            end
          end
        end
        WAIT_R, ACCUM: begin
          if (accum_last) begin
            state_reg  <= DRAIN;
            r_ready_o  <= 1'b0;
            valid_o    <= 1'b1;
            poly_sel_o <= 1'b0;
            // Tile 0 may be the one being written right now.
            coeff_o    <= (r_addr == '0) ? sum_tile : res_buf[0];
          end else if (r_take) begin
            state_reg <= ACCUM;
          end
        end
        DRAIN: begin
          if (drain_take) begin
            if (o_cnt_reg == LAST_IDX) begin
              state_reg  <= LOAD_D;
              valid_o    <= 1'b0;
              d_ready_o  <= 1'b1;
              o_cnt_reg  <= '0;
              c0_cnt_reg <= '0;
              c1_cnt_reg <= '0;
            end else begin
              o_cnt_reg  <= o_cnt_next;
              coeff_o    <= res_buf[o_cnt_next];
              poly_sel_o <= (o_cnt_next >= NT_IDX);
            end
          end
        end
        default: state_reg <= LOAD_D;
      endcase
    end
  end
endmodule

// File: tb/tb_relin_accumulate.sv
// Scoreboard bench for relin_accumulate: expected ct tiles queued as relin beats are driven.
module tb_relin_accumulate;
  import relin_accumulate_pkg::*;

  localparam int TW = TILE_N * BIT_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          d_valid_i = 1'b0;
  logic          d_ready_o;
  logic [TW-1:0] d_coeff_i = '0;
  logic          r_valid_i = 1'b0;
  logic          r_key_select_i = 1'b0;
  logic [TW-1:0] r_coeff_i = '0;
  logic          r_ready_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic          poly_sel_o;
  logic [TW-1:0] coeff_o;
  logic          error_o;

  int vectors = 0;
  int miscompares = 0;

  logic [TW-1:0] d_model [2*NT];
  logic [TW-1:0] r_model [2*NT];
  logic [TW-1:0] exp_q [$];
  logic          exp_sel_q [$];

  always #5 clk = ~clk;

  relin_accumulate dut (
    .clk            (clk),
    .rst            (rst),
    .d_valid_i      (d_valid_i),
    .d_ready_o      (d_ready_o),
    .d_coeff_i      (d_coeff_i),
    .r_valid_i      (r_valid_i),
    .r_key_select_i (r_key_select_i),
    .r_coeff_i      (r_coeff_i),
    .r_ready_o      (r_ready_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .poly_sel_o     (poly_sel_o),
    .coeff_o        (coeff_o),
    .error_o        (error_o)
  );

  function automatic logic [TW-1:0] fill(input logic [BIT_WIDTH-1:0] v);
    logic [TW-1:0] t;
    for (int l = 0; l < TILE_N; l++) t[l*BIT_WIDTH +: BIT_WIDTH] = v;
    return t;
  endfunction

  function automatic logic [TW-1:0] model_sum(input logic [TW-1:0] d, input logic [TW-1:0] r);
    logic [TW-1:0] t;
    longint unsigned s;
    for (int l = 0; l < TILE_N; l++) begin
      s = (longint'(d[l*BIT_WIDTH +: BIT_WIDTH]) + longint'(r[l*BIT_WIDTH +: BIT_WIDTH])) % longint'(Q);
      t[l*BIT_WIDTH +: BIT_WIDTH] = s[BIT_WIDTH-1:0];
    end
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vals(input logic [BIT_WIDTH-1:0] d0, input logic [BIT_WIDTH-1:0] d1,
                          input logic [BIT_WIDTH-1:0] r0, input logic [BIT_WIDTH-1:0] r1);
    for (int i = 0; i < NT; i++) begin
      d_model[i] = fill(d0);  d_model[NT+i] = fill(d1);
      r_model[i] = fill(r0);  r_model[NT+i] = fill(r1);
    end
  endtask

  task automatic load_d();
    int n = 0;
    while (d_ready_o !== 1'b1 && n < 20) begin step(); n++; end
    vectors++;
    if (d_ready_o !== 1'b1) begin
      $display("FAIL load_wait: d_ready_o=%b required 1 within 20 cycles", d_ready_o);
      miscompares++;
    end
    for (int i = 0; i < 2*NT; i++) begin
      d_valid_i = 1'b1;
      d_coeff_i = d_model[i];
      step();
    end
    d_valid_i = 1'b0;
    vectors++;
    if ({d_ready_o, r_ready_o} !== 2'b01) begin
      $display("FAIL load_handoff: d_ready/r_ready=%b%b required 01", d_ready_o, r_ready_o);
      miscompares++;
    end
  endtask

  task automatic run_relin(input int gap);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NT; i++) begin
        if (k == 1 && i == NT-1) begin
          vectors++;
          if (valid_o !== 1'b0) begin
            $display("FAIL early_valid: valid_o=%b required 0 before last relin beat", valid_o);
            miscompares++;
          end
        end
        r_valid_i      = 1'b1;
        r_key_select_i = (k == 1);
        r_coeff_i      = r_model[k*NT+i];
        exp_q.push_back(model_sum(d_model[k*NT+i], r_model[k*NT+i]));
        exp_sel_q.push_back(k == 1);
        step();
      end
      r_valid_i = 1'b0;
      if (k == 0) repeat (gap) step();
    end
    vectors++;
    if (valid_o !== 1'b1) begin
      $display("FAIL latency: valid_o=%b required 1 one cycle after last relin beat", valid_o);
      miscompares++;
    end
  endtask

  // Monitor side of the scoreboard; mode 1 applies the ready pattern 1,0,0,1.
  task automatic drain(input int mode);
    logic          pat [4];
    logic          held_valid = 1'b0;
    logic [TW-1:0] held = '0;
    logic [TW-1:0] exp_t;
    logic          exp_s;
    int beats = 0;
    int cyc = 0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    while (beats < 2*NT && cyc < 200) begin
      if (held_valid) begin
        vectors++;
        if (valid_o !== 1'b1 || coeff_o !== held) begin
          $display("FAIL hold: valid=%b coeff=%h required 1 %h", valid_o, coeff_o, held);
          miscompares++;
        end
      end
      ready_i = (mode == 1) ? pat[cyc % 4] : 1'b1;
      if (valid_o === 1'b1 && ready_i) begin
        vectors++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_beat: coeff=%h with empty scoreboard", coeff_o);
          miscompares++;
        end else begin
          exp_t = exp_q.pop_front();
          exp_s = exp_sel_q.pop_front();
          if (coeff_o !== exp_t || poly_sel_o !== exp_s) begin
            $display("FAIL beat%0d: sel=%b coeff=%h required sel=%b coeff=%h",
                     beats, poly_sel_o, coeff_o, exp_s, exp_t);
            miscompares++;
          end
        end
        beats++;
        held_valid = 1'b0;
      end else if (valid_o === 1'b1) begin
        held_valid = 1'b1;
        held = coeff_o;
      end
      step();
      cyc++;
    end
    ready_i = 1'b0;
    vectors++;
    if (beats != 2*NT) begin
      $display("FAIL drain_timeout: got %0d beats required %0d", beats, 2*NT);
      miscompares++;
    end
    vectors++;
    if (valid_o !== 1'b0 || d_ready_o !== 1'b1) begin
      $display("FAIL post_drain: valid=%b d_ready=%b required 0 1", valid_o, d_ready_o);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    vectors++;
    if ({d_ready_o, r_ready_o, valid_o, poly_sel_o, error_o} !== 5'b0 || coeff_o !== '0) begin
      $display("FAIL reset_state: rdy=%b rr=%b v=%b sel=%b err=%b coeff=%h required all 0",
               d_ready_o, r_ready_o, valid_o, poly_sel_o, error_o, coeff_o);
      miscompares++;
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({d_ready_o, r_ready_o, valid_o} !== 3'b100) begin
      $display("FAIL reset_release: d_ready/r_ready/valid=%b%b%b required 100",
               d_ready_o, r_ready_o, valid_o);
      miscompares++;
    end
  endtask

  task automatic test_basic();
    set_vals(1, 2, 5, Q - 1);
    load_d();
    run_relin(0);
    drain(0);
    vectors++;
    if (error_o !== 1'b0) begin
      $display("FAIL basic_error: error_o=%b required 0", error_o);
      miscompares++;
    end
  endtask

  task automatic test_wrap();
    set_vals(Q - 1, Q - 1, 3*Q + 2, 3*Q + 2);
    load_d();
    run_relin(0);
    drain(0);
  endtask

  task automatic test_backpressure();
    set_vals(7, 100, Q + 3, 2*Q - 5);
    for (int i = 0; i < 2*NT; i++) d_model[i] = d_model[i] + fill(BIT_WIDTH'(i * 11));
    load_d();
    run_relin(0);
    drain(1);
  endtask

  task automatic test_gapped();
    set_vals(1, 2, 5, Q - 1);
    load_d();
    run_relin(3);
    drain(0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 2*NT; i++)
      for (int l = 0; l < TILE_N; l++) begin
        d_model[i][l*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'($urandom_range(int'(Q) - 1, 0));
        r_model[i][l*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'($urandom());
      end
    load_d();
    run_relin(1);
    drain(1);
  endtask

  task automatic test_protocol_error();
    set_vals(1, 2, 5, Q - 1);
    load_d();
    run_relin(0);
    ready_i        = 1'b0;
    r_valid_i      = 1'b1;
    r_key_select_i = 1'b1;
    r_coeff_i      = fill(9);
    step();
    r_valid_i = 1'b0;
    vectors++;
    if (error_o !== 1'b1) begin
      $display("FAIL error_set: error_o=%b required 1", error_o);
      miscompares++;
    end
    drain(0);
    vectors++;
    if (error_o !== 1'b1) begin
      $display("FAIL error_sticky: error_o=%b required 1", error_o);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_accum();
    set_vals(4, 8, 20, 30);
    load_d();
    for (int i = 0; i < 3; i++) begin
      r_valid_i      = 1'b1;
      r_key_select_i = 1'b0;
      r_coeff_i      = r_model[i];
      step();
    end
    r_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if ({valid_o, r_ready_o, d_ready_o, error_o} !== 4'b0) begin
      $display("FAIL reset_abort: v=%b rr=%b dr=%b err=%b required 0000",
               valid_o, r_ready_o, d_ready_o, error_o);
      miscompares++;
    end
    step();
    rst = 1'b1;
    step();
    vectors++;
    if (d_ready_o !== 1'b1 || valid_o !== 1'b0) begin
      $display("FAIL reset_resume: d_ready=%b valid=%b required 1 0", d_ready_o, valid_o);
      miscompares++;
    end
    exp_q.delete();
    exp_sel_q.delete();
    set_vals(3, 6, Q + 1, 2);
    load_d();
    run_relin(0);
    drain(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_gapped();
    test_random();
    test_protocol_error();
    test_reset_mid_accum();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
